// File: rtl/cordic_rotate.sv
// cordic_rotate: iterative CORDIC rotation giving unscaled cos/sin of a clamped angle,
// one iteration per enabled clock edge.
module cordic_rotate #(
  parameter int W = 12,
  parameter int FXP_SHIFT = 10,
  parameter int N = 10
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         ce,
  input  logic         start,
  input  logic [W-1:0] angle_in,
  output logic [W-1:0] x_out,
  output logic [W-1:0] y_out,
  output logic [W-1:0] t_angle,
  output logic         valid,
  output logic         busy
);
  localparam int XW = W + 2;
  typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;
  state_t state, state_nx;
  logic signed [XW-1:0] x, y, z, x_nx, y_nx, z_nx, atan;
  logic signed [W-1:0] ang, ang_c;
  logic [3:0] i;
  logic accept, last, z_neg;
  assign ang = $signed(angle_in);
  assign ang_c = ang > 1608 ? W'(1608) : ang < -1608 ? W'(-1608) : ang;
  always_comb begin
    case (i)
      4'd0: atan = XW'(804);
      4'd1: atan = XW'(475);
      4'd2: atan = XW'(251);
      4'd3: atan = XW'(127);
      4'd4: atan = XW'(64);
      4'd5: atan = XW'(32);
      4'd6: atan = XW'(16);
      4'd7: atan = XW'(8);
      4'd8: atan = XW'(4);
      default: atan = XW'(2);
    endcase
  end
  // rotate towards z = 0: a negative residual angle turns the vector clockwise
  assign z_neg = z[XW-1];
  assign x_nx = z_neg ? x + (y >>> i) : x - (y >>> i);
  assign y_nx = z_neg ? y - (x >>> i) : y + (x >>> i);
  assign z_nx = z_neg ? z + atan : z - atan;
  assign accept = ce && start && state != ROTATE;
  assign last = ce && state == ROTATE && i == 4'(N - 1);
  assign busy = state == ROTATE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ROTATE : IDLE;
      ROTATE:  state_nx = i == 4'(N - 1) ? DONE : ROTATE;
      DONE:    state_nx = start ? ROTATE : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else if (ce) state <= state_nx;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
      z <= '0;
      i <= '0;
      x_out <= '0;
      y_out <= '0;
      t_angle <= '0;
      valid <= 1'b0;
    end else if (ce) begin
      valid <= last;
      if (accept) begin
        x <= XW'(1 << FXP_SHIFT);
        y <= '0;
        z <= {{2{ang_c[W-1]}}, ang_c};
        i <= '0;
        t_angle <= ang_c;
      end else if (state == ROTATE) begin
        x <= x_nx;
        y <= y_nx;
        z <= z_nx;
        i <= i + 4'd1;
      end
      if (last) begin
        x_out <= x_nx[W-1:0];
        y_out <= y_nx[W-1:0];
      end
    end
  end
endmodule

// File: doc/cordic_rotate.md
CORDIC_ROTATE -- requirements
Module: cordic_rotate

Interface
REQ-001 The module SHALL have parameter W, default 12, giving the width of the fixed-point (12:10) data.
REQ-002 The module SHALL have parameter FXP_SHIFT, default 10, giving the number of fraction bits.
REQ-003 The module SHALL have parameter N, default 10, giving the number of CORDIC iterations (legal range 1..10).
REQ-004 The ports SHALL be as follows, one per line, clock and reset first:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- ce  input  1  clock enable; when 0, every register holds its value.
- start  input  1  request a rotation of angle_in; sampled when ce=1.
- angle_in  input  W  signed angle in radians, (12:10) format.
- x_out  output  W  signed unscaled cosine (gain ~1.6468), (12:10) format; feeds mul_Kn.
- y_out  output  W  signed unscaled sine, (12:10) format; feeds mul_Kn.
- t_angle  output  W  clamped angle of the current result, forwarded to mul_Kn.
- valid  output  1  one-ce-cycle pulse; x_out, y_out and t_angle hold a new result.
- busy  output  1  high while state is ROTATE.

Function
REQ-005 The FSM SHALL have three states: IDLE, ROTATE and DONE.
REQ-006 Transitions SHALL advance only on edges where ce=1.
- IDLE or DONE, with start=1 -> ROTATE.
- ROTATE, with iteration counter = N-1 -> DONE.
- DONE, with start=0 -> IDLE.
REQ-007 The start-accept edge SHALL load the registers as follows:
- x = 1<<FXP_SHIFT (1024).
- y = 0.
- z = clamped angle_in.
- iteration counter i = 0.
- t_angle = clamped angle_in.
REQ-008 The clamp SHALL limit angle_in to the range -1608..+1608 (±pi/2).
REQ-009 When start=1 is sampled in ROTATE, the module SHALL ignore it, with no queueing.
REQ-010 Each ROTATE edge with ce=1 SHALL perform one iteration i.
- If z>=0: x'=x-(y>>>i), y'=y+(x>>>i), z'=z-ATAN[i].
- Else: x'=x+(y>>>i), y'=y-(x>>>i), z'=z+ATAN[i].
- The shifts SHALL be arithmetic; the counter i SHALL then increment.
REQ-011 ATAN[0..9] SHALL be the constants 804, 475, 251, 127, 64, 32, 16, 8, 4, 2 (atan(2^-i)·1024, rounded).
REQ-012 Internal x, y and z SHALL be W+2 bits, sign-extended on load.
REQ-013 x_out and y_out SHALL be the low W bits of the final x and y; the clamp of REQ-008 guarantees no overflow.
REQ-014 On the edge that performs iteration N-1, the module SHALL register x_out and y_out and set valid=1.
- Latency: N ce-enabled edges from the start-accept edge to valid high (10 for the default N).
REQ-015 valid SHALL deassert on the next ce=1 edge.
REQ-016 A start=1 in DONE SHALL be accepted on the same edge that clears valid (back-to-back operation, one result per N+1 cycles).
REQ-017 x_out, y_out and t_angle SHALL hold their values until the next result is registered.
REQ-018 While ce=0, all registers SHALL freeze; valid, if high, SHALL stay high until the next ce=1 edge.
REQ-019 busy SHALL be combinational from state: 1 in ROTATE, 0 otherwise.

Reset
REQ-020 reset_n=0 SHALL, asynchronously and regardless of ce, force the following:
- state = IDLE.
- x_out = 0, y_out = 0, t_angle = 0.
- valid = 0.
- internal x, y, z and i = 0.
REQ-021 A reset during ROTATE SHALL abort the operation with no valid pulse.
REQ-022 After reset_n rises, the first start with ce=1 SHALL be accepted normally.

Verification
REQ-023 The bench SHALL cover the following directed scenarios, with tolerance ±6 LSB on x_out and y_out.
- angle_in=0, start pulse, ce=1 -> valid exactly 10 edges later; x_out≈1686, y_out≈0, t_angle=0.
- angle_in=804 (pi/4) -> x_out≈1192, y_out≈1192; then angle_in=-804 -> x_out≈1192, y_out≈-1192.
- angle_in=2047 (out of range) -> t_angle=1608, x_out≈0, y_out≈1686; angle_in=-2048 -> t_angle=-1608, y_out≈-1686.
- start held high continuously with angle_in=0 -> start ignored while busy=1; valid pulses every 11 edges; each result correct.
- ce low for 3 cycles mid-ROTATE -> valid delayed by exactly 3 cycles; result identical to the uninterrupted run.
- reset_n pulsed low at iteration 5 -> all outputs 0 immediately, no valid; a new start afterwards -> correct result after 10 edges.
